// File: rtl/shared_pkg.sv
// Shared ALSU types: opcode tags and the result record captured downstream.
package shared_pkg;

  typedef enum logic [2:0] {
    OR        = 3'd0,
    XOR       = 3'd1,
    ADD       = 3'd2,
    MULT      = 3'd3,
    SHIFT     = 3'd4,
    ROTATE    = 3'd5,
    INVALID_6 = 3'd6,
    INVALID_7 = 3'd7
  } opcode_e;

  localparam int RES_W = 6;

  typedef struct packed {
    logic signed [RES_W-1:0] data;
    opcode_e                 op;
    logic                    invalid;
  } alsu_result_t;

  // Min/max trackers start at the opposite extremes so the first store wins.
  localparam logic signed [RES_W-1:0] RES_MAX_RST = -6'sd32;
  localparam logic signed [RES_W-1:0] RES_MIN_RST = 6'sd31;

endpackage

// File: rtl/alsu_sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
module alsu_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/alsu_result_collector.sv
// Show-ahead result FIFO behind the ALSU with drop/invalid statistics and
// running signed min/max of stored results.
module alsu_result_collector
  import shared_pkg::*;
#(
  parameter int    DEPTH        = 4,
  parameter string DROP_INVALID = "OFF",
  parameter int    CNT_W        = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [RES_W-1:0]  in_out,
  input  opcode_e                  in_opcode,
  input  logic                     in_invalid,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [RES_W-1:0]  out_data,
  output opcode_e                  out_opcode,
  output logic                     out_invalid,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_cnt,
  output logic [CNT_W-1:0]         invalid_cnt,
  output logic signed [RES_W-1:0]  res_max,
  output logic signed [RES_W-1:0]  res_min
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam bit FILTER_INVALID = (DROP_INVALID == "ON");

  alsu_result_t            mem_q [DEPTH];
  alsu_result_t            in_res, head;
  alsu_result_t            last_q, last_d;
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    overflow_q, overflow_d;
  logic signed [RES_W-1:0] max_q, max_d, min_q, min_d;
  logic                    is_full, is_empty;
  logic                    storable, pop, push, drop, inv_seen;

  always_comb begin
    in_res   = '{data: in_out, op: in_opcode, invalid: in_invalid};
    is_full  = (count_q == FULL_CNT);
    is_empty = (count_q == '0);
    storable = in_valid && !(FILTER_INVALID && in_invalid);
    pop      = !is_empty && out_ready;
    push     = storable && (!is_full || pop);
    drop     = storable && is_full && !pop;
    inv_seen = in_valid && in_invalid;
    // When empty, the head shows the last popped entry so outputs hold.
    head     = is_empty ? last_q : mem_q[rd_ptr_q];
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    last_d     = last_q;
    overflow_d = overflow_q || drop;
    max_d      = max_q;
    min_d      = min_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      last_d   = mem_q[rd_ptr_q];
    end
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
    if (push && (in_out > max_q)) max_d = in_out;
    if (push && (in_out < min_q)) min_d = in_out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      last_q     <= '0;
      overflow_q <= 1'b0;
      max_q      <= RES_MAX_RST;
      min_q      <= RES_MIN_RST;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      last_q     <= last_d;
      overflow_q <= overflow_d;
      max_q      <= max_d;
      min_q      <= min_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_ptr_q] <= in_res;
  end

  alsu_sat_counter #(.W(CNT_W)) u_drop_cnt (
    .clk (clk),
    .rst (rst),
    .inc (drop),
    .cnt (drop_cnt)
  );

  alsu_sat_counter #(.W(CNT_W)) u_invalid_cnt (
    .clk (clk),
    .rst (rst),
    .inc (inv_seen),
    .cnt (invalid_cnt)
  );

  assign out_valid   = !is_empty;
  assign out_data    = head.data;
  assign out_opcode  = head.op;
  assign out_invalid = head.invalid;
  assign full        = is_full;
  assign empty       = is_empty;
  assign count       = count_q;
  assign overflow    = overflow_q;
  assign res_max     = max_q;
  assign res_min     = min_q;

endmodule

// File: tb/tb_alsu_result_collector.sv
// Directed bench for alsu_result_collector with a queue scoreboard and model.
module tb_alsu_result_collector;
  import shared_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_invalid, out_ready;
  logic [5:0] in_out;
  opcode_e in_opcode;

  logic       out_valid, out_invalid, full, empty, overflow;
  logic [5:0] out_data, res_max, res_min;
  opcode_e    out_opcode;
  logic [2:0] count;
  logic [CNT_W-1:0] drop_cnt, invalid_cnt;

  logic       on_out_valid, on_out_invalid, on_full, on_empty, on_overflow;
  logic [5:0] on_out_data, on_res_max, on_res_min;
  opcode_e    on_out_opcode;
  logic [2:0] on_count;
  logic [CNT_W-1:0] on_drop_cnt, on_invalid_cnt;

  alsu_result_collector #(.DEPTH(DEPTH), .DROP_INVALID("OFF"), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_out(in_out),
    .in_opcode(in_opcode), .in_invalid(in_invalid), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_opcode(out_opcode),
    .out_invalid(out_invalid), .full(full), .empty(empty), .count(count),
    .overflow(overflow), .drop_cnt(drop_cnt), .invalid_cnt(invalid_cnt),
    .res_max(res_max), .res_min(res_min)
  );

  alsu_result_collector #(.DEPTH(DEPTH), .DROP_INVALID("ON"), .CNT_W(CNT_W)) dut_on (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_out(in_out),
    .in_opcode(in_opcode), .in_invalid(in_invalid), .out_valid(on_out_valid),
    .out_ready(out_ready), .out_data(on_out_data), .out_opcode(on_out_opcode),
    .out_invalid(on_out_invalid), .full(on_full), .empty(on_empty), .count(on_count),
    .overflow(on_overflow), .drop_cnt(on_drop_cnt), .invalid_cnt(on_invalid_cnt),
    .res_max(on_res_max), .res_min(on_res_min)
  );

  always #5 clk = ~clk;

  // Scoreboard and reference model for the DROP_INVALID="OFF" instance
  alsu_result_t     q[$];
  alsu_result_t     m_last;
  logic             m_ovf;
  logic [CNT_W-1:0] m_drop, m_inv;
  logic signed [5:0] m_max, m_min;
  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_last = '0;
    m_ovf  = 1'b0;
    m_drop = '0;
    m_inv  = '0;
    m_max  = -6'sd32;
    m_min  = 6'sd31;
  endtask

  task automatic check_state(input string tag);
    alsu_result_t h;
    h = (q.size() > 0) ? q[0] : m_last;
    chk({tag, ".count"},       32'(count),        32'(q.size()));
    chk({tag, ".empty"},       32'(empty),        32'(q.size() == 0));
    chk({tag, ".full"},        32'(full),         32'(q.size() == DEPTH));
    chk({tag, ".out_valid"},   32'(out_valid),    32'(q.size() != 0));
    chk({tag, ".overflow"},    32'(overflow),     32'(m_ovf));
    chk({tag, ".drop_cnt"},    32'(drop_cnt),     32'(m_drop));
    chk({tag, ".invalid_cnt"}, 32'(invalid_cnt),  32'(m_inv));
    chk({tag, ".res_max"},     32'(res_max),      32'($unsigned(m_max)));
    chk({tag, ".res_min"},     32'(res_min),      32'($unsigned(m_min)));
    chk({tag, ".out_data"},    32'(out_data),     32'($unsigned(h.data)));
    chk({tag, ".out_opcode"},  32'(out_opcode),   32'(h.op));
    chk({tag, ".out_invalid"}, 32'(out_invalid),  32'(h.invalid));
  endtask

  // Drives one cycle of stimulus, updates the model, and advances past the edge.
  task automatic step(input logic v, input logic signed [5:0] d, input opcode_e op,
                      input logic inv, input logic rdy);
    logic m_pop, m_push, m_drop_ev;
    alsu_result_t r;
    in_valid = v; in_out = d; in_opcode = op; in_invalid = inv; out_ready = rdy;
    #1;
    m_pop = (q.size() > 0) && rdy;
    if (q.size() == 0) chk("no_bypass.out_valid", 32'(out_valid), 32'd0);
    if (m_pop) begin
      chk("pop.data", 32'(out_data), 32'($unsigned(q[0].data)));
      chk("pop.op",   32'(out_opcode), 32'(q[0].op));
      m_last = q.pop_front();
    end
    m_push    = v && ((q.size() + (m_pop ? 1 : 0)) < DEPTH || m_pop);
    m_drop_ev = v && !m_push;
    if (m_push) begin
      r = '{data: d, op: op, invalid: inv};
      q.push_back(r);
      if (d > m_max) m_max = d;
      if (d < m_min) m_min = d;
    end
    if (m_drop_ev) begin
      m_ovf = 1'b1;
      if (m_drop != CNT_SAT) m_drop++;
    end
    if (v && inv && (m_inv != CNT_SAT)) m_inv++;
    @(posedge clk);
    #1;
    in_valid = 1'b0; out_ready = 1'b0; in_invalid = 1'b0;
  endtask

  task automatic idle_pop();
    step(1'b0, 6'sd0, OR, 1'b0, 1'b1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_out = '0; in_opcode = OR; in_invalid = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check_state("reset");

    // Test 1: three pushes, no consumer
    step(1'b1, 6'sd5, ADD, 1'b0, 1'b0);
    chk("t1.first_visible", 32'(out_data), 32'd5);
    step(1'b1, -6'sd3, MULT, 1'b0, 1'b0);
    step(1'b1, 6'sd0, OR, 1'b0, 1'b0);
    check_state("t1");
    chk("t1.res_max_const", 32'(res_max), 32'd5);
    chk("t1.res_min_const", 32'(res_min), 32'h3D);

    // Test 2: fill, overflow drop, then drain in order
    step(1'b1, 6'sd1, ROTATE, 1'b0, 1'b0);
    check_state("t2.full");
    step(1'b1, 6'sd7, XOR, 1'b0, 1'b0);
    check_state("t2.drop");
    chk("t2.drop_cnt_const", 32'(drop_cnt), 32'd1);
    for (int i = 0; i < 4; i++) idle_pop();
    check_state("t2.drained");

    // Test 3: full FIFO with simultaneous push and pop
    step(1'b1, 6'sd2, ADD, 1'b0, 1'b0);
    step(1'b1, 6'sd3, OR, 1'b0, 1'b0);
    step(1'b1, 6'sd4, XOR, 1'b0, 1'b0);
    step(1'b1, -6'sd1, MULT, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, -6'sd32, SHIFT, 1'b0, 1'b1);
      check_state("t3.pushpop");
    end
    chk("t3.res_min_const", 32'(res_min), 32'h20);
    for (int i = 0; i < 4; i++) idle_pop();
    check_state("t3.drained");

    // Test 4: invalid result with filtering on and off
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check_state("t4.reset");
    step(1'b1, 6'sd1, INVALID_6, 1'b1, 1'b0);
    check_state("t4.off");
    chk("t4.off.out_invalid", 32'(out_invalid), 32'd1);
    chk("t4.on.count",        32'(on_count), 32'd0);
    chk("t4.on.out_valid",    32'(on_out_valid), 32'd0);
    chk("t4.on.invalid_cnt",  32'(on_invalid_cnt), 32'd1);

    // Test 5: drop counter saturation
    step(1'b1, 6'sd10, ADD, 1'b0, 1'b0);
    step(1'b1, -6'sd10, INVALID_7, 1'b0, 1'b0);
    step(1'b1, 6'sd3, SHIFT, 1'b0, 1'b0);
    for (int i = 0; i < 260; i++) step(1'b1, 6'sd9, OR, 1'b0, 1'b0);
    check_state("t5.sat");
    chk("t5.drop_cnt_const", 32'(drop_cnt), 32'd255);

    // Test 6: reset wins over push and pop at count=2
    idle_pop();
    idle_pop();
    check_state("t6.pre");
    rst = 1'b1; in_valid = 1'b1; in_out = 6'sd12; in_opcode = ADD; out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    model_reset();
    check_state("t6.post");
    chk("t6.on.invalid_cnt", 32'(on_invalid_cnt), 32'd0);
    chk("t6.on.drop_cnt",    32'(on_drop_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
